// File: rtl/ahb_master_ctrl_if.sv
// Requester command/response channel and AHB master-side bus signals of ahb_master_ctrl.
// Handshake: a command transfers on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse with no back-pressure.
interface ahb_master_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        hbusreq;
   logic        hgrant;
   logic [31:0] haddr;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic [1:0]  hresp;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      input  hgrant, hrdata, hready, hresp,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output hbusreq, haddr, hwrite, htrans, hsize, hburst, hwdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      output hgrant, hrdata, hready, hresp,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  hbusreq, haddr, hwrite, htrans, hsize, hburst, hwdata
   );
endinterface

// File: rtl/ahb_master_ctrl.sv
// Single-transfer AHB master: arbitrates, runs address/data phases, handles wait states
// and two-cycle ERROR/RETRY/SPLIT responses with a bounded re-issue count.
module ahb_master_ctrl #(
   parameter int unsigned MAX_RETRY = 4
) (
   input  logic              hclk,
   input  logic              hreset,
   ahb_master_ctrl_if.master bus,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_ADDR  = 3'd2,
      S_DATA  = 3'd3,
      S_RESP2 = 3'd4
   } state_t;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_ERROR   = 2'b01;
   localparam logic [3:0] MAX_RETRY_C  = 4'(MAX_RETRY);

   state_t      state_q;
   logic        cmd_write_q;
   logic [31:0] cmd_addr_q;
   logic [31:0] cmd_wdata_q;
   logic [3:0]  retry_cnt_q;
   logic [1:0]  resp_q;
   logic        req_ready_q;
   logic        hbusreq_q;
   logic [1:0]  htrans_q;
   logic [31:0] haddr_q;
   logic        hwrite_q;
   logic [31:0] hwdata_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q     <= S_IDLE;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         retry_cnt_q <= '0;
         resp_q      <= RESP_OKAY;
         req_ready_q <= 1'b1;
         hbusreq_q   <= 1'b0;
         htrans_q    <= TRANS_IDLE;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  cmd_write_q <= bus.req_write;
                  cmd_addr_q  <= bus.req_addr;
                  cmd_wdata_q <= bus.req_wdata;
                  retry_cnt_q <= '0;
                  req_ready_q <= 1'b0;
                  hbusreq_q   <= 1'b1;
                  state_q     <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.hgrant && bus.hready) begin
                  htrans_q  <= TRANS_NONSEQ;
                  haddr_q   <= cmd_addr_q;
                  hwrite_q  <= cmd_write_q;
                  hbusreq_q <= 1'b0;
                  state_q   <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (bus.hready) begin
                  htrans_q <= TRANS_IDLE;
                  hwdata_q <= cmd_write_q ? cmd_wdata_q : 32'h0;
                  state_q  <= S_DATA;
               end
            end
            S_DATA: begin
               if (bus.hready) begin
                  // A single-cycle non-OKAY response is malformed; report it as an error.
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= (bus.hresp != RESP_OKAY);
                  rsp_rdata_q <= (!cmd_write_q && bus.hresp == RESP_OKAY) ? bus.hrdata : 32'h0;
               end else if (bus.hresp != RESP_OKAY) begin
                  resp_q  <= bus.hresp;
                  state_q <= S_RESP2;
               end
            end
            S_RESP2: begin
               if (bus.hready) begin
                  if (resp_q != RESP_ERROR && retry_cnt_q < MAX_RETRY_C) begin
                     retry_cnt_q <= retry_cnt_q + 4'd1;
                     hbusreq_q   <= 1'b1;
                     state_q     <= S_REQ;
                  end else begin
                     state_q     <= S_IDLE;
                     req_ready_q <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= 32'h0;
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
               hbusreq_q   <= 1'b0;
               htrans_q    <= TRANS_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.hbusreq   = hbusreq_q;
   assign bus.haddr     = haddr_q;
   assign bus.hwrite    = hwrite_q;
   assign bus.htrans    = htrans_q;
   assign bus.hsize     = 3'b010;
   assign bus.hburst    = 3'b000;
   assign bus.hwdata    = hwdata_q;
   assign dbg_state_o   = state_q;

endmodule

// File: doc/ahb_master_ctrl.md
# ahb_master_ctrl

Single-transfer AHB bus master. It accepts one read or write command at a time from a local requester and arbitrates for the bus through the arbiter's request/grant pair. It runs the AHB address and data phases against the decoder/slave fabric, and returns read data or an error status to the requester. It handles wait states and the two-cycle ERROR/RETRY/SPLIT responses produced by the AHB slave interfaces, re-issuing RETRY/SPLIT transfers up to a bounded count.

## Interface
Parameters:
- MAX_RETRY, 4, re-issue attempts after RETRY/SPLIT before reporting error (1..15)

Ports:
- hclk  in  1  master clock; all state updates on rising edge
- hreset  in  1  asynchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  high in IDLE; command accepted on edge with req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  transfer address (word aligned)
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data, valid with rsp_valid (0 for writes)
- rsp_err  out  1  valid with rsp_valid; 1 = ERROR or retry limit exhausted
- hbusreq  out  1  bus request to arbiter
- hgrant  in  1  grant from arbiter
- haddr  out  32  AHB address
- hwrite  out  1  AHB direction
- htrans  out  2  00 IDLE, 10 NONSEQ; BUSY/SEQ never driven
- hsize  out  3  constant 010 (word)
- hburst  out  3  constant 000 (SINGLE)
- hwdata  out  32  AHB write data
- hrdata  in  32  AHB read data
- hready  in  1  transfer done / bus ready
- hresp  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT

## Operation
- Command capture: on acceptance, latch req_write, req_addr and req_wdata into internal registers, and clear the retry counter (4 bits).
- States and transitions:
  - IDLE: req_ready=1, hbusreq=0. On accept -> REQ.
  - REQ: hbusreq=1. On an edge with hgrant=1 && hready=1 -> ADDR.
  - ADDR: htrans=NONSEQ, haddr and hwrite from the latched command, hbusreq=0. On hready=1 -> DATA. On hready=0, hold ADDR and keep all outputs stable.
  - DATA: htrans=IDLE; hwdata = latched data for writes (held for the whole phase), 0 for reads.
    - hready=1 && hresp=OKAY -> IDLE; register rsp_valid=1, rsp_err=0, rsp_rdata=hrdata (read) or 0 (write).
    - hready=0 && hresp=OKAY -> wait state; stay in DATA.
    - hready=0 && hresp!=OKAY -> RESP2, with the response code latched.
  - RESP2: htrans=IDLE. Wait for hready=1, then:
    - ERROR -> IDLE; rsp_valid=1, rsp_err=1, rsp_rdata=0.
    - RETRY/SPLIT with retry_cnt<MAX_RETRY -> increment retry_cnt, go to REQ and re-issue the identical transfer.
    - RETRY/SPLIT with retry_cnt==MAX_RETRY -> IDLE; rsp_valid=1, rsp_err=1.
- Outside ADDR, htrans is always IDLE. haddr and hwrite hold their last values.
- An OKAY response with hready=1 in RESP2 is treated as the latched code (latched code governs).

## Timing
- Reset values (asynchronous, immediate): state IDLE, req_ready=1, hbusreq=0, htrans=00, haddr=0, hwrite=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, retry_cnt=0. hsize and hburst are constant.
- Reset mid-transfer: the command is discarded and no rsp_valid is produced.
- Minimum latency, with hgrant=1 and hready=1 throughout: accept at edge E0, ADDR in cycle after E1, DATA after E2, rsp_valid high for the cycle after E3.
- Each wait state adds one cycle.
- rsp_valid is high for exactly one cycle, during which state is IDLE. A new command may be accepted in that same cycle.
- hbusreq drops in the first ADDR cycle.
- Loss of hgrant while in REQ simply holds REQ.

## Test plan
- Zero-wait write, addr 0x0000_0010, data 0xDEAD_BEEF, hgrant=1: NONSEQ one cycle, hwdata=0xDEAD_BEEF next cycle, rsp_valid 3 cycles after accept, rsp_err=0.
- Read with 2 wait states, slave returns 0x1234_5678: DATA lasts 3 cycles, rsp_rdata=0x1234_5678, latency 5 cycles.
- Delayed grant: hgrant low 4 cycles after request: hbusreq stays high and htrans stays IDLE until grant; transfer then completes normally.
- ERROR two-cycle response: hready=0/hresp=01, then hready=1/hresp=01 -> rsp_valid with rsp_err=1, no re-issue.
- RETRY on every attempt with MAX_RETRY=4: exactly 5 NONSEQ address phases (1 + 4 re-issues), then rsp_err=1. A RETRY once followed by OKAY gives rsp_err=0 after 2 address phases.
- Assert hreset during DATA of a write: all outputs at reset values in the same cycle, no rsp_valid, req_ready=1 after release.
